// File: rtl/cc_dir_banked_rmw_pkg.sv
// cc_dir_pkg: shared definitions for the banked read-modify-write directory store.
// Holds the build configuration, the derived bank/row/lane geometry, the FSM
// state type and the lane-merge helper used when a partial-mask write folds
// new data into the old row contents.
// No ports (package).
package cc_dir_pkg;

  // Build configuration; the top-level parameters default to these values.
  localparam int CFG_ADDR_W      = 10;
  localparam int CFG_DATA_W      = 136;
  localparam int CFG_MASK_W      = 8;
  localparam int CFG_MACRO_DEPTH = 128;
  localparam int CFG_MACRO_W     = 256;

  // Derived geometry: banks come from the high address bits, rows from the low.
  localparam int NBANKS = (1 << CFG_ADDR_W) / CFG_MACRO_DEPTH;
  localparam int BANK_W = $clog2(NBANKS);
  localparam int ROW_W  = $clog2(CFG_MACRO_DEPTH);
  localparam int LANE_W = CFG_DATA_W / CFG_MASK_W;

  // IDLE accepts requests; RMW_WR is the write-back half of a partial write.
  typedef enum logic {
    IDLE   = 1'b0,
    RMW_WR = 1'b1
  } state_t;

  // Lane k of the result takes the new data when mask[k] is set, else keeps old.
  function automatic logic [CFG_DATA_W-1:0] merge_lanes(
    input logic [CFG_DATA_W-1:0] old_data,
    input logic [CFG_DATA_W-1:0] new_data,
    input logic [CFG_MASK_W-1:0] mask
  );
    logic [CFG_DATA_W-1:0] result;
    result = old_data;
    for (int k = 0; k < CFG_MASK_W; k++) begin
      if (mask[k]) begin
        result[k*LANE_W +: LANE_W] = new_data[k*LANE_W +: LANE_W];
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/cc_dir_banked_rmw_if.sv
// cc_dir_banked_rmw_if: request/response bundle of the banked RMW store.
// Signals:
//   req_valid  requester -> store   request present
//   req_ready  store -> requester   request accepted when high with req_valid
//   req_addr   requester -> store   word address
//   req_wmode  requester -> store   1 = write, 0 = read
//   req_wdata  requester -> store   write data
//   req_wmask  requester -> store   per-lane write enable
//   resp_valid store -> requester   one-cycle read-data pulse, no backpressure
//   resp_rdata store -> requester   read data
// Modports: master (requester side), slave (store side).
interface cc_dir_banked_rmw_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 136,
  parameter int MASK_W = 8
);

  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic              req_wmode;
  logic [DATA_W-1:0] req_wdata;
  logic [MASK_W-1:0] req_wmask;
  logic              resp_valid;
  logic [DATA_W-1:0] resp_rdata;

  modport master (
    output req_valid, req_addr, req_wmode, req_wdata, req_wmask,
    input  req_ready, resp_valid, resp_rdata
  );

  modport slave (
    input  req_valid, req_addr, req_wmode, req_wdata, req_wmask,
    output req_ready, resp_valid, resp_rdata
  );

endinterface

// File: rtl/SRAM1RW128x256.sv
// SRAM1RW128x256: behavioural model of the 128-word x 256-bit single-port macro.
// Ports:
//   CE   in   macro clock, accesses happen on its rising edge
//   CSB  in   chip select, active low; no access while high
//   WEB  in   write enable, active low (high = read)
//   OEB  in   output enable, active low; output reads 0 while high
//   A    in   7-bit row address
//   I    in   256-bit write data
//   O    out  256-bit read data, valid the cycle after a read access
// Contents are never cleared; the output register holds across writes and idles.
module SRAM1RW128x256 (
  input  logic         CE,
  input  logic         CSB,
  input  logic         WEB,
  input  logic         OEB,
  input  logic [6:0]   A,
  input  logic [255:0] I,
  output logic [255:0] O
);

  logic [255:0] mem [128];
  logic [255:0] q;

  // Synchronous single-port array: one write or one read per selected edge.
  always_ff @(posedge CE) begin
    if (!CSB) begin
      if (!WEB) begin
        mem[A] <= I;
      end else begin
        q <= mem[A];
      end
    end
  end

  assign O = OEB ? '0 : q;

endmodule

// File: rtl/cc_dir_banked_rmw_bank.sv
// cc_dir_bank: one bank of the store, wrapping a single SRAM1RW128x256 macro.
// Ports:
//   clock  in   store clock, drives the macro CE
//   cs     in   bank selected this cycle (active high)
//   we     in   write when selected (active high), else read
//   row    in   row within the bank
//   wdata  in   logical write data, zero-padded to the macro width
//   rdata  out  logical read data, truncated from the macro output
module cc_dir_bank #(
  parameter int ROW_W   = 7,
  parameter int DATA_W  = 136,
  parameter int MACRO_W = 256
) (
  input  logic              clock,
  input  logic              cs,
  input  logic              we,
  input  logic [ROW_W-1:0]  row,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [MACRO_W-1:0] macro_wdata;
  logic [MACRO_W-1:0] macro_rdata;
  logic               unused_macro_hi;

  // Spare macro columns are always written as zero and never looked at again.
  assign macro_wdata     = {{(MACRO_W-DATA_W){1'b0}}, wdata};
  assign rdata           = macro_rdata[DATA_W-1:0];
  assign unused_macro_hi = ^macro_rdata[MACRO_W-1:DATA_W];

  SRAM1RW128x256 u_sram (
    .CE  (clock),
    .CSB (~cs),
    .WEB (~we),
    .OEB (1'b0),
    .A   (row),
    .I   (macro_wdata),
    .O   (macro_rdata)
  );

endmodule

// File: rtl/cc_dir_banked_rmw.sv
// cc_dir_banked_rmw: banked directory store with masked writes.
// Ports:
//   clock  in   sole clock, all state on its rising edge
//   reset  in   asynchronous active-high reset
//   bus    slave side of cc_dir_banked_rmw_if (request/response handshake)
// Reads take two cycles to a registered response and pipeline one per cycle.
// Full-mask writes go straight to the macro, empty-mask writes are dropped, and
// partial-mask writes read the row, then write back the merged word a cycle
// later while the request side is held off.
module cc_dir_banked_rmw
  import cc_dir_pkg::*;
#(
  parameter int ADDR_W      = CFG_ADDR_W,
  parameter int DATA_W      = CFG_DATA_W,
  parameter int MASK_W      = CFG_MASK_W,
  parameter int MACRO_DEPTH = CFG_MACRO_DEPTH,
  parameter int MACRO_W     = CFG_MACRO_W
) (
  input logic            clock,
  input logic            reset,
  cc_dir_banked_rmw_if.slave bus
);

  localparam int NB = (1 << ADDR_W) / MACRO_DEPTH;
  localparam int RW = $clog2(MACRO_DEPTH);
  localparam int BW = $clog2(NB);

  state_t            state;
  logic [ADDR_W-1:0] cap_addr;
  logic [DATA_W-1:0] cap_wdata;
  logic [MASK_W-1:0] cap_wmask;

  logic              rd_p1;
  logic [BW-1:0]     bank_p1;
  logic              resp_valid_q;
  logic [DATA_W-1:0] resp_rdata_q;

  logic              accept;
  logic              mask_full;
  logic              mask_none;
  logic              acc_cs;
  logic              acc_we;
  logic [ADDR_W-1:0] acc_addr;
  logic [DATA_W-1:0] acc_wdata;
  logic [DATA_W-1:0] merged;
  logic [NB-1:0]     bank_cs;
  logic [DATA_W-1:0] bank_rdata [NB];

  assign accept    = bus.req_valid && (state == IDLE);
  assign mask_full = &bus.req_wmask;
  assign mask_none = ~|bus.req_wmask;

  assign bus.req_ready  = (state == IDLE);
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_rdata = resp_rdata_q;

  // The row read at the start of a partial write comes back from the captured
  // bank one cycle later; fold the captured lanes into it.
  assign merged = merge_lanes(bank_rdata[cap_addr[ADDR_W-1:RW]], cap_wdata, cap_wmask);

  // Macro access for this cycle. The write-back of a partial write owns the
  // macros in RMW_WR; otherwise the accepted request decides. Everything is
  // gated by reset so an edge seen while reset is high never touches a macro,
  // which is what aborts a write-back caught by reset.
  always_comb begin
    acc_cs    = 1'b0;
    acc_we    = 1'b0;
    acc_addr  = bus.req_addr;
    acc_wdata = bus.req_wdata;
    if (!reset) begin
      if (state == RMW_WR) begin
        acc_cs    = 1'b1;
        acc_we    = 1'b1;
        acc_addr  = cap_addr;
        acc_wdata = merged;
      end else if (accept) begin
        if (!bus.req_wmode) begin
          acc_cs = 1'b1;
        end else if (mask_full) begin
          acc_cs = 1'b1;
          acc_we = 1'b1;
        end else if (!mask_none) begin
          acc_cs = 1'b1;
        end
      end
    end
  end

  // One-hot chip select: only the addressed bank sees the access.
  always_comb begin
    bank_cs = '0;
    if (acc_cs) begin
      bank_cs[acc_addr[ADDR_W-1:RW]] = 1'b1;
    end
  end

  for (genvar b = 0; b < NB; b++) begin : g_bank
    cc_dir_bank #(
      .ROW_W   (RW),
      .DATA_W  (DATA_W),
      .MACRO_W (MACRO_W)
    ) u_bank (
      .clock (clock),
      .cs    (bank_cs[b]),
      .we    (acc_we),
      .row   (acc_addr[RW-1:0]),
      .wdata (acc_wdata),
      .rdata (bank_rdata[b])
    );
  end

  // Control FSM plus the read pipeline. The bank of each read travels with it
  // so the response mux picks the right macro even when a partial write has
  // started reading a different bank in the meantime.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      cap_addr     <= '0;
      cap_wdata    <= '0;
      cap_wmask    <= '0;
      rd_p1        <= 1'b0;
      bank_p1      <= '0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
    end else begin
      rd_p1        <= accept && !bus.req_wmode;
      resp_valid_q <= rd_p1;
      if (accept) begin
        bank_p1 <= bus.req_addr[ADDR_W-1:RW];
      end
      if (rd_p1) begin
        resp_rdata_q <= bank_rdata[bank_p1];
      end
      case (state)
        IDLE: begin
          if (accept && bus.req_wmode && !mask_full && !mask_none) begin
            state     <= RMW_WR;
            cap_addr  <= bus.req_addr;
            cap_wdata <= bus.req_wdata;
            cap_wmask <= bus.req_wmask;
          end
        end
        RMW_WR: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
